// File: rtl/bus_mux_encoded.sv
// Registered priority-encoded bus mux with multi-driver detection and counting.
// Latency: 1 cycle from sampled src_out/src_data to bus_out/sel_idx.
// Backpressure: none; bus captures only on enabled edges and otherwise holds.
// Optional build macro: BUS_MUX_CONFLICT_CNT_EN (conflict counter flops).
module bus_mux_encoded #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 32,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_out,
  input  logic                   enable,
  input  logic                   conflict_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [SEL_W-1:0]       sel_idx,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic             any_strobe;
  logic             multi_strobe;
  logic             seen;
  logic             conf_evt;

  logic [WIDTH-1:0] bus_d, bus_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic             conf_d, conf_q;
  logic             sticky_d, sticky_q;

  // Priority encode: scan high to low so the lowest set strobe is written last and wins.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        win_idx  = SEL_W'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Detect zero / one / more-than-one strobes without a full popcount.
  always_comb begin
    seen         = 1'b0;
    multi_strobe = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_out[i]) begin
        if (seen) multi_strobe = 1'b1;
        seen = 1'b1;
      end
    end
    any_strobe = seen;
  end

  assign conf_evt = enable & multi_strobe;

  // Next-state for the bus capture and conflict flags; data and index hold when idle.
  always_comb begin
    bus_d    = bus_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    conf_d   = conf_evt;
    sticky_d = sticky_q;
    if (enable) begin
      valid_d = any_strobe;
      if (any_strobe) begin
        bus_d = win_data;
        sel_d = win_idx;
      end
    end
    // A fresh conflict takes priority over a clear in the same cycle.
    if (conf_evt) begin
      sticky_d = 1'b1;
    end else if (conflict_clr) begin
      sticky_d = 1'b0;
    end
  end

  // Bus and flag registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      bus_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      conf_q   <= conf_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef BUS_MUX_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Saturating conflict counter; a conflict alongside a clear restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (conf_evt) begin
      if (conflict_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (conflict_clr) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

  assign bus_out         = bus_q;
  assign bus_valid       = valid_q;
  assign sel_idx         = sel_q;
  assign conflict        = conf_q;
  assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_bus_mux_encoded.sv
// Bench for bus_mux_encoded: 32-source/CNT_W=2 and 18-source/CNT_W=8 instances.
// Latency: checks every cycle 1 ns after the rising edge against a behavioural model.
// Backpressure: not applicable; directed vectors plus literal expectations.
module tb_bus_mux_encoded;

`ifdef BUS_MUX_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clear_n;
  logic [31:0]  words [32];
  logic [31:0]  strobe;
  logic         enable;
  logic         conflict_clr;
  logic [1023:0] pack_a;

  logic [31:0] bus_a, bus_b;
  logic        valid_a, valid_b;
  logic [4:0]  sel_a, sel_b;
  logic        conf_a, conf_b;
  logic        sticky_a, sticky_b;
  logic [1:0]  cnt_a;
  logic [7:0]  cnt_b;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] m_bus    [2];
  logic [4:0]  m_sel    [2];
  bit          m_valid  [2];
  bit          m_conf   [2];
  bit          m_sticky [2];
  int          m_cnt    [2];
  bit          model_ok = 1'b0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 32; g++) begin : g_pack
    assign pack_a[g*32 +: 32] = words[g];
  end

  bus_mux_encoded #(.WIDTH(32), .N_SRC(32), .CNT_W(2)) dut_a (
    .clock(clock), .clear_n(clear_n), .src_data(pack_a), .src_out(strobe),
    .enable(enable), .conflict_clr(conflict_clr),
    .bus_out(bus_a), .bus_valid(valid_a), .sel_idx(sel_a), .conflict(conf_a),
    .conflict_sticky(sticky_a), .conflict_cnt(cnt_a)
  );

  bus_mux_encoded #(.WIDTH(32), .N_SRC(18), .CNT_W(8)) dut_b (
    .clock(clock), .clear_n(clear_n), .src_data(pack_a[18*32-1:0]), .src_out(strobe[17:0]),
    .enable(enable), .conflict_clr(conflict_clr),
    .bus_out(bus_b), .bus_valid(valid_b), .sel_idx(sel_b), .conflict(conf_b),
    .conflict_sticky(sticky_b), .conflict_cnt(cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count strobes within the instance's source range, lowest index wins.
  task automatic model_step();
    int n, win, pc, cmax;
    bit hit;
    for (int k = 0; k < 2; k++) begin
      n    = (k == 0) ? 32 : 18;
      cmax = (k == 0) ? 3 : 255;
      pc   = 0;
      win  = -1;
      for (int i = 0; i < n; i++) begin
        if (strobe[i]) begin
          pc++;
          if (win < 0) win = i;
        end
      end
      if (!clear_n) begin
        m_bus[k] = 0; m_sel[k] = 0; m_valid[k] = 0;
        m_conf[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
        model_ok = 1'b1;
      end else begin
        hit = enable && (pc >= 2);
        if (enable) begin
          m_valid[k] = (pc > 0);
          if (pc > 0) begin
            m_bus[k] = words[win];
            m_sel[k] = 5'(win);
          end
        end
        m_conf[k] = hit;
        if (hit) m_sticky[k] = 1;
        else if (conflict_clr) m_sticky[k] = 0;
        if (CNT_EN) begin
          if (hit) m_cnt[k] = conflict_clr ? 1 : ((m_cnt[k] < cmax) ? m_cnt[k] + 1 : m_cnt[k]);
          else if (conflict_clr) m_cnt[k] = 0;
        end
      end
    end
  endtask

  // Model update on each edge, then compare every output 1 ns later.
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      if (model_ok) begin
        chk("a.bus_out", 64'(bus_a), 64'(m_bus[0]));
        chk("a.bus_valid", 64'(valid_a), 64'(m_valid[0]));
        chk("a.sel_idx", 64'(sel_a), 64'(m_sel[0]));
        chk("a.conflict", 64'(conf_a), 64'(m_conf[0]));
        chk("a.sticky", 64'(sticky_a), 64'(m_sticky[0]));
        chk("a.cnt", 64'(cnt_a), 64'(m_cnt[0]));
        chk("b.bus_out", 64'(bus_b), 64'(m_bus[1]));
        chk("b.bus_valid", 64'(valid_b), 64'(m_valid[1]));
        chk("b.sel_idx", 64'(sel_b), 64'(m_sel[1]));
        chk("b.conflict", 64'(conf_b), 64'(m_conf[1]));
        chk("b.sticky", 64'(sticky_b), 64'(m_sticky[1]));
        chk("b.cnt", 64'(cnt_b), 64'(m_cnt[1]));
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    clear_n = 1'b0; enable = 1'b0; conflict_clr = 1'b0; strobe = '0;
    for (int i = 0; i < 32; i++) words[i] = 32'h0100_0000 + 32'(i);
    cycle(); cycle();
    chk("lit.reset.bus", 64'(bus_a), 64'h0);
    chk("lit.reset.valid", 64'(valid_a), 64'h0);
    chk("lit.reset.sel", 64'(sel_a), 64'h0);

    // Single source.
    clear_n = 1'b1; enable = 1'b1;
    words[5] = 32'hDEAD_BEEF; strobe = 32'h1 << 5;
    cycle();
    chk("lit.single.bus", 64'(bus_a), 64'hDEAD_BEEF);
    chk("lit.single.sel", 64'(sel_a), 64'd5);
    chk("lit.single.valid", 64'(valid_a), 64'd1);
    chk("lit.single.conf", 64'(conf_a), 64'd0);

    // Multi-driver: sources 3 and 17.
    words[3] = 32'h1111_1111; strobe = (32'h1 << 3) | (32'h1 << 17);
    cycle();
    chk("lit.multi.bus", 64'(bus_a), 64'h1111_1111);
    chk("lit.multi.sel", 64'(sel_a), 64'd3);
    chk("lit.multi.conf", 64'(conf_a), 64'd1);
    chk("lit.multi.sticky", 64'(sticky_a), 64'd1);
    chk("lit.multi.cnt", 64'(cnt_a), CNT_EN ? 64'd1 : 64'd0);
    chk("lit.multi.b.conf", 64'(conf_b), 64'd1);

    // Hold behaviour.
    words[0] = 32'hA5A5_A5A5; strobe = 32'h1;
    cycle();
    chk("lit.pulse.conf", 64'(conf_a), 64'd0);
    strobe = '0;
    cycle();
    chk("lit.hold.bus", 64'(bus_a), 64'hA5A5_A5A5);
    chk("lit.hold.valid", 64'(valid_a), 64'd0);
    enable = 1'b0; words[2] = 32'h1234_5678; strobe = 32'h1 << 2;
    cycle();
    chk("lit.dis.bus", 64'(bus_a), 64'hA5A5_A5A5);
    chk("lit.dis.sel", 64'(sel_a), 64'd0);

    // Clear, then saturate the counter.
    conflict_clr = 1'b1;
    cycle();
    chk("lit.clr.sticky", 64'(sticky_a), 64'd0);
    chk("lit.clr.cnt", 64'(cnt_a), 64'd0);
    conflict_clr = 1'b0; enable = 1'b1; strobe = 32'h3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lit.sat.cnt", 64'(cnt_a), CNT_EN ? 64'(sat_exp[i]) : 64'd0);
    end
    conflict_clr = 1'b1;
    cycle();
    chk("lit.clrconf.cnt", 64'(cnt_a), CNT_EN ? 64'd1 : 64'd0);
    chk("lit.clrconf.sticky", 64'(sticky_a), 64'd1);
    enable = 1'b0; strobe = '0;
    cycle();
    chk("lit.clronly.cnt", 64'(cnt_a), 64'd0);
    chk("lit.clronly.sticky", 64'(sticky_a), 64'd0);
    conflict_clr = 1'b0;

    // Reset mid-stream, then release with source 31 (out of range for the 18-source copy).
    enable = 1'b1; strobe = 32'h1 << 9; clear_n = 1'b0;
    cycle();
    chk("lit.midrst.bus", 64'(bus_a), 64'h0);
    chk("lit.midrst.valid", 64'(valid_a), 64'h0);
    clear_n = 1'b1; words[31] = 32'hCAFE_0031; strobe = 32'h1 << 31;
    cycle();
    chk("lit.rel.sel", 64'(sel_a), 64'd31);
    chk("lit.rel.b.valid", 64'(valid_b), 64'd0);

    // Top source of the 18-source copy, then a strobe beyond its range.
    words[17] = 32'h0000_0017; strobe = 32'h1 << 17;
    cycle();
    chk("lit.n18.sel", 64'(sel_b), 64'd17);
    chk("lit.n18.bus", 64'(bus_b), 64'h17);
    strobe = 32'h1 << 20;
    cycle();
    chk("lit.n18.oor.valid", 64'(valid_b), 64'd0);
    chk("lit.n18.oor.sel", 64'(sel_b), 64'd17);
    strobe = (32'h1 << 4) | (32'h1 << 12);
    cycle();
    chk("lit.n18.conf.sticky", 64'(sticky_b), 64'd1);
    chk("lit.n18.conf.cnt", 64'(cnt_b), CNT_EN ? 64'd1 : 64'd0);
    enable = 1'b0; strobe = '0;
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
